// File: rtl/sd_init_sequencer.sv
// sd_init_sequencer: SPI-mode SD card power-up sequencer.
// Drives the card chip select through the dummy-clock and settle windows.
// It then issues CMD0, CMD55/ACMD41 (retried while the card reports idle),
// CMD58 and optionally CMD16 through an external command module.
// Ports:
//   i_clk, i_rst_n                     clock, async active-low reset
//   i_start                            start pulse (honoured in IDLE/DONE/ERROR only)
//   o_sd_cs                            card chip select
//   o_send_cmd/o_cmd_select/o_cmd_arg  one-cycle command request to the command module
//   i_confirm_pin/i_response_status    command module ack/response strobe and R1 status code
//   o_busy/o_init_finished/o_clk_fast  progress and completion
//   o_init_error/o_error_code/o_error_cmd/o_retry_count  failure report and ACMD41 attempts
module sd_init_sequencer #(
    parameter int unsigned DUMMY_CYCLES   = 75,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned ACMD41_RETRIES = 255,
    parameter logic [31:0] ACMD41_ARG     = 32'h4000_0000,
    parameter bit          USE_CMD16      = 1'b1,
    parameter int unsigned BLOCK_LEN      = 512,
    parameter int unsigned RSP_TIMEOUT    = 65535,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    output logic        o_sd_cs,
    output logic        o_send_cmd,
    output logic [2:0]  o_cmd_select,
    output logic [31:0] o_cmd_arg,
    input  logic        i_confirm_pin,
    input  logic [7:0]  i_response_status,
    output logic        o_busy,
    output logic        o_init_finished,
    output logic        o_clk_fast,
    output logic        o_init_error,
    output logic [7:0]  o_error_code,
    output logic [2:0]  o_error_cmd,
    output logic [7:0]  o_retry_count
);

    localparam logic [2:0] NO_CMD = 3'd0;
    localparam logic [2:0] C_CMD0 = 3'd1;
    localparam logic [2:0] C_CMD16 = 3'd2;
    localparam logic [2:0] C_CMD55 = 3'd5;
    localparam logic [2:0] C_CMD58 = 3'd6;
    localparam logic [2:0] C_CMD41 = 3'd7;

    localparam logic [CNT_W-1:0] DUMMY_LAST  = CNT_W'(DUMMY_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(RSP_TIMEOUT - 1);
    localparam logic [7:0]       RETRY_MAX   = 8'(ACMD41_RETRIES);
    localparam logic [7:0]       ERR_TMO     = 8'hF0;
    localparam logic [7:0]       ERR_RETRY   = 8'hF1;
    localparam logic [7:0]       ST_NO_ERR   = 8'd1;
    localparam logic [7:0]       ST_IDLE     = 8'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_CS_HIGH, S_CS_SETTLE, S_CMD0, S_CMD55,
        S_ACMD41, S_CMD58, S_CMD16, S_DONE, S_ERROR
    } state_t;

    typedef enum logic [2:0] {
        P_SELECT, P_DRIVE, P_WAIT_ACK, P_WAIT_RSP, P_EVAL
    } phase_t;

    function automatic logic [2:0] cmd_code(input state_t s);
        case (s)
            S_CMD0:   cmd_code = C_CMD0;
            S_CMD55:  cmd_code = C_CMD55;
            S_ACMD41: cmd_code = C_CMD41;
            S_CMD58:  cmd_code = C_CMD58;
            S_CMD16:  cmd_code = C_CMD16;
            default:  cmd_code = NO_CMD;
        endcase
    endfunction

    function automatic logic [31:0] cmd_arg(input state_t s);
        case (s)
            S_ACMD41: cmd_arg = ACMD41_ARG;
            S_CMD16:  cmd_arg = 32'(BLOCK_LEN);
            default:  cmd_arg = 32'h0;
        endcase
    endfunction

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        rsp_q, rsp_d;
    logic              cs_q, cs_d, send_q, send_d, busy_q, busy_d;
    logic              fin_q, fin_d, fast_q, fast_d, err_q, err_d;
    logic [2:0]        sel_q, sel_d, ecmd_q, ecmd_d;
    logic [31:0]       arg_q, arg_d;
    logic [7:0]        code_q, code_d, retry_q, retry_d;
    logic              launch, fail, go_done;
    logic [7:0]        fail_code;
    logic              rsp_ok12;

    // State and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            phase_q <= P_SELECT;
            cnt_q   <= '0;
            rsp_q   <= '0;
            cs_q    <= 1'b1;
            send_q  <= 1'b0;
            sel_q   <= NO_CMD;
            arg_q   <= '0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            fast_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
            ecmd_q  <= NO_CMD;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
            cs_q    <= cs_d;
            send_q  <= send_d;
            sel_q   <= sel_d;
            arg_q   <= arg_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
            fast_q  <= fast_d;
            err_q   <= err_d;
            code_q  <= code_d;
            ecmd_q  <= ecmd_d;
            retry_q <= retry_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        rsp_d     = rsp_q;
        cs_d      = cs_q;
        send_d    = 1'b0;
        sel_d     = sel_q;
        arg_d     = arg_q;
        fin_d     = fin_q;
        fast_d    = fast_q;
        err_d     = err_q;
        code_d    = code_q;
        ecmd_d    = ecmd_q;
        retry_d   = retry_q;
        launch    = 1'b0;
        fail      = 1'b0;
        go_done   = 1'b0;
        fail_code = 8'h00;
        rsp_ok12  = (rsp_q == ST_NO_ERR) || (rsp_q == ST_IDLE);

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    state_d = S_CS_HIGH;
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    fin_d   = 1'b0;
                    fast_d  = 1'b0;
                    err_d   = 1'b0;
                    code_d  = 8'h00;
                    ecmd_d  = NO_CMD;
                    retry_d = 8'h00;
                end
            end
            S_CS_HIGH: begin
                if (cnt_q == DUMMY_LAST) begin
                    state_d = S_CS_SETTLE;
                    cnt_d   = '0;
                    cs_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CS_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_CMD0;
                    launch  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CMD0, S_CMD55, S_ACMD41, S_CMD58, S_CMD16: begin
                case (phase_q)
                    P_SELECT: phase_d = P_DRIVE;
                    P_DRIVE: begin
                        phase_d = P_WAIT_ACK;
                        cnt_d   = '0;
                    end
                    P_WAIT_ACK: begin
                        if (i_confirm_pin) begin
                            sel_d   = NO_CMD;
                            phase_d = P_WAIT_RSP;
                            cnt_d   = '0;
                        end else if (cnt_q == TMO_LAST) begin
                            fail      = 1'b1;
                            fail_code = ERR_TMO;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    P_WAIT_RSP: begin
                        if (i_confirm_pin) begin
                            rsp_d   = i_response_status;
                            phase_d = P_EVAL;
                        end else if (cnt_q == TMO_LAST) begin
                            fail      = 1'b1;
                            fail_code = ERR_TMO;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        // EVAL: any status not listed as success is reported as-is
                        fail      = 1'b1;
                        fail_code = rsp_q;
                        case (state_q)
                            S_CMD0: if (rsp_ok12) begin
                                fail = 1'b0; state_d = S_CMD55; launch = 1'b1;
                            end
                            S_CMD55: if (rsp_ok12) begin
                                fail = 1'b0; state_d = S_ACMD41; launch = 1'b1;
                            end
                            S_ACMD41: begin
                                if (rsp_q == ST_NO_ERR) begin
                                    fail = 1'b0; state_d = S_CMD58; launch = 1'b1;
                                end else if (rsp_q == ST_IDLE) begin
                                    // retry_q already counts the attempt just made
                                    if (retry_q < RETRY_MAX) begin
                                        fail = 1'b0; state_d = S_CMD55; launch = 1'b1;
                                    end else begin
                                        fail_code = ERR_RETRY;
                                    end
                                end
                            end
                            S_CMD58: if (rsp_q == ST_NO_ERR) begin
                                fail = 1'b0;
                                if (USE_CMD16) begin
                                    state_d = S_CMD16; launch = 1'b1;
                                end else begin
                                    go_done = 1'b1;
                                end
                            end
                            default: if (rsp_q == ST_NO_ERR) begin
                                fail = 1'b0; go_done = 1'b1;
                            end
                        endcase
                    end
                endcase
            end
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            code_d  = fail_code;
            ecmd_d  = cmd_code(state_q);
            cs_d    = 1'b1;
            sel_d   = NO_CMD;
        end else if (go_done) begin
            state_d = S_DONE;
            fin_d   = 1'b1;
            fast_d  = 1'b1;
            cs_d    = 1'b0;
            sel_d   = NO_CMD;
        end

        // Entering a command: one-cycle request; ACMD41 attempts counted here, saturating
        if (launch) begin
            phase_d = P_SELECT;
            send_d  = 1'b1;
            sel_d   = cmd_code(state_d);
            arg_d   = cmd_arg(state_d);
            if (state_d == S_ACMD41 && retry_q != 8'hFF) begin
                retry_d = retry_q + 8'd1;
            end
        end

        busy_d = !(state_d inside {S_IDLE, S_DONE, S_ERROR});
    end

    assign o_sd_cs         = cs_q;
    assign o_send_cmd      = send_q;
    assign o_cmd_select    = sel_q;
    assign o_cmd_arg       = arg_q;
    assign o_busy          = busy_q;
    assign o_init_finished = fin_q;
    assign o_clk_fast      = fast_q;
    assign o_init_error    = err_q;
    assign o_error_code    = code_q;
    assign o_error_cmd     = ecmd_q;
    assign o_retry_count   = retry_q;

endmodule

// File: tb/tb_sd_init_sequencer.sv
// tb_sd_init_sequencer: scoreboard bench for sd_init_sequencer.
// Two instances share clock, reset and card responder: dut_a uses default
// parameters, dut_b uses ACMD41_RETRIES=3 and RSP_TIMEOUT=100. sel_b picks
// which instance the responder and scoreboard observe.
module tb_sd_init_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start_a, start_b, confirm, sel_b;
    logic [7:0]  status;

    logic        a_cs, a_send, a_busy, a_fin, a_fast, a_err;
    logic [2:0]  a_sel, a_ecmd;
    logic [31:0] a_arg;
    logic [7:0]  a_code, a_retry;
    logic        b_cs, b_send, b_busy, b_fin, b_fast, b_err;
    logic [2:0]  b_sel, b_ecmd;
    logic [31:0] b_arg;
    logic [7:0]  b_code, b_retry;

    logic        m_cs, m_send, m_busy, m_fin, m_fast, m_err;
    logic [2:0]  m_sel, m_ecmd;
    logic [31:0] m_arg;
    logic [7:0]  m_code, m_retry;

    sd_init_sequencer dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a),
        .o_sd_cs(a_cs), .o_send_cmd(a_send), .o_cmd_select(a_sel), .o_cmd_arg(a_arg),
        .i_confirm_pin(confirm), .i_response_status(status),
        .o_busy(a_busy), .o_init_finished(a_fin), .o_clk_fast(a_fast),
        .o_init_error(a_err), .o_error_code(a_code), .o_error_cmd(a_ecmd),
        .o_retry_count(a_retry)
    );

    sd_init_sequencer #(.ACMD41_RETRIES(3), .RSP_TIMEOUT(100)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b),
        .o_sd_cs(b_cs), .o_send_cmd(b_send), .o_cmd_select(b_sel), .o_cmd_arg(b_arg),
        .i_confirm_pin(confirm), .i_response_status(status),
        .o_busy(b_busy), .o_init_finished(b_fin), .o_clk_fast(b_fast),
        .o_init_error(b_err), .o_error_code(b_code), .o_error_cmd(b_ecmd),
        .o_retry_count(b_retry)
    );

    always_comb begin
        m_cs    = sel_b ? b_cs    : a_cs;
        m_send  = sel_b ? b_send  : a_send;
        m_busy  = sel_b ? b_busy  : a_busy;
        m_fin   = sel_b ? b_fin   : a_fin;
        m_fast  = sel_b ? b_fast  : a_fast;
        m_err   = sel_b ? b_err   : a_err;
        m_sel   = sel_b ? b_sel   : a_sel;
        m_ecmd  = sel_b ? b_ecmd  : a_ecmd;
        m_arg   = sel_b ? b_arg   : a_arg;
        m_code  = sel_b ? b_code  : a_code;
        m_retry = sel_b ? b_retry : a_retry;
    end

    typedef struct packed {
        logic [2:0]  cmd;
        logic [31:0] arg;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // card responder configuration
    logic [7:0] st_cmd0, st_cmd55, st_cmd58, st_cmd16, acmd_dflt;
    logic [7:0] acmd_q[$];
    logic [2:0] silent_cmd, ackonly_cmd, twocyc_cmd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    task automatic push(input logic [2:0] c, input logic [31:0] a);
        exp_t e;
        e.cmd = c;
        e.arg = a;
        exp_q.push_back(e);
    endtask

    task automatic push_nominal();
        push(3'd1, 32'h0); push(3'd5, 32'h0); push(3'd7, 32'h4000_0000);
        push(3'd6, 32'h0); push(3'd2, 32'd512);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(m_fin || m_err) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("end_reached", 32'(m_fin || m_err), 32'd1);
    endtask

    // Monitor: every command request is popped against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m_send) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_cmd: got cmd %0d arg %0h want none", m_sel, m_arg);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_code", 32'(m_sel), 32'(e.cmd));
                    chk("cmd_arg", m_arg, e.arg);
                end
            end
        end
    end

    // Card responder: ack strobe, then response strobe with status
    initial begin
        logic [2:0] c;
        logic [7:0] s;
        confirm = 1'b0;
        status  = 8'h00;
        forever begin
            @(negedge clk);
            if (m_send) begin
                c = m_sel;
                case (c)
                    3'd1:    s = st_cmd0;
                    3'd5:    s = st_cmd55;
                    3'd7:    s = (acmd_q.size() != 0) ? acmd_q.pop_front() : acmd_dflt;
                    3'd6:    s = st_cmd58;
                    3'd2:    s = st_cmd16;
                    default: s = 8'h00;
                endcase
                if (c != silent_cmd) begin
                    repeat (2) @(negedge clk);
                    if (c == twocyc_cmd) begin
                        status  = s;
                        confirm = 1'b1;
                        repeat (2) @(negedge clk);
                        confirm = 1'b0;
                    end else begin
                        confirm = 1'b1;
                        @(negedge clk);
                        confirm = 1'b0;
                        if (c != ackonly_cmd) begin
                            repeat (2) @(negedge clk);
                            status  = s;
                            confirm = 1'b1;
                            @(negedge clk);
                            confirm = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic chk_reset_values();
        chk("rst_cs", 32'(m_cs), 32'd1);
        chk("rst_send", 32'(m_send), 32'd0);
        chk("rst_sel", 32'(m_sel), 32'd0);
        chk("rst_arg", m_arg, 32'd0);
        chk("rst_busy", 32'(m_busy), 32'd0);
        chk("rst_fin", 32'(m_fin), 32'd0);
        chk("rst_fast", 32'(m_fast), 32'd0);
        chk("rst_err", 32'(m_err), 32'd0);
        chk("rst_code", 32'(m_code), 32'd0);
        chk("rst_ecmd", 32'(m_ecmd), 32'd0);
        chk("rst_retry", 32'(m_retry), 32'd0);
    endtask

    initial begin
        int hi, lo, n, t;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; sel_b = 1'b0;
        st_cmd0 = 8'd2; st_cmd55 = 8'd1; st_cmd58 = 8'd1; st_cmd16 = 8'd1; acmd_dflt = 8'd1;
        silent_cmd = 3'd0; ackonly_cmd = 3'd0; twocyc_cmd = 3'd0;

        // reset state, then idle with no commands
        repeat (3) @(negedge clk);
        chk_reset_values();
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_busy", 32'(m_busy), 32'd0);
        chk("idle_cs", 32'(m_cs), 32'd1);

        // nominal, CMD58 answered with a two-cycle strobe
        push_nominal();
        acmd_q = '{8'd1};
        twocyc_cmd = 3'd6;
        pulse_start();
        hi = 0;
        while (m_busy && m_cs && hi < 1000) begin hi++; @(negedge clk); end
        lo = 0;
        while (!m_send && lo < 1000) begin lo++; @(negedge clk); end
        chk("cs_high_cycles", hi, 75);
        chk("settle_cycles", lo, 16);
        wait_end();
        chk("nom_fin", 32'(m_fin), 32'd1);
        chk("nom_fast", 32'(m_fast), 32'd1);
        chk("nom_cs", 32'(m_cs), 32'd0);
        chk("nom_busy", 32'(m_busy), 32'd0);
        chk("nom_err", 32'(m_err), 32'd0);
        chk("nom_retry", 32'(m_retry), 32'd1);
        chk("nom_queue", exp_q.size(), 0);
        twocyc_cmd = 3'd0;

        // retry: three idle replies to ACMD41, plus an ignored mid-run start
        push(3'd1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            push(3'd5, 32'h0);
            push(3'd7, 32'h4000_0000);
        end
        push(3'd6, 32'h0);
        push(3'd2, 32'd512);
        acmd_q = '{8'd2, 8'd2, 8'd2, 8'd1};
        pulse_start();
        chk("restart_fin_clr", 32'(m_fin), 32'd0);
        chk("restart_fast_clr", 32'(m_fast), 32'd0);
        chk("restart_busy", 32'(m_busy), 32'd1);
        repeat (150) @(negedge clk);
        pulse_start();
        wait_end();
        chk("retry_fin", 32'(m_fin), 32'd1);
        chk("retry_count", 32'(m_retry), 32'd4);
        chk("retry_queue", exp_q.size(), 0);

        // CRC error on CMD58, then restart clears the error report
        push(3'd1, 32'h0); push(3'd5, 32'h0); push(3'd7, 32'h4000_0000); push(3'd6, 32'h0);
        acmd_q = '{8'd1};
        st_cmd58 = 8'd6;
        pulse_start();
        wait_end();
        chk("crc_err", 32'(m_err), 32'd1);
        chk("crc_code", 32'(m_code), 32'd6);
        chk("crc_ecmd", 32'(m_ecmd), 32'd6);
        chk("crc_cs", 32'(m_cs), 32'd1);
        chk("crc_busy", 32'(m_busy), 32'd0);
        chk("crc_fin", 32'(m_fin), 32'd0);
        chk("crc_queue", exp_q.size(), 0);
        st_cmd58 = 8'd1;
        push_nominal();
        acmd_q = '{8'd1};
        pulse_start();
        chk("clr_err", 32'(m_err), 32'd0);
        chk("clr_code", 32'(m_code), 32'd0);
        chk("clr_ecmd", 32'(m_ecmd), 32'd0);
        chk("clr_cs", 32'(m_cs), 32'd1);
        wait_end();
        chk("rerun_fin", 32'(m_fin), 32'd1);
        chk("rerun_queue", exp_q.size(), 0);

        // retry exhaustion on the 3-retry instance
        sel_b = 1'b1;
        acmd_dflt = 8'd2;
        push(3'd1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            push(3'd5, 32'h0);
            push(3'd7, 32'h4000_0000);
        end
        pulse_start();
        wait_end();
        chk("exh_err", 32'(m_err), 32'd1);
        chk("exh_code", 32'(m_code), 32'hF1);
        chk("exh_ecmd", 32'(m_ecmd), 32'd7);
        chk("exh_retry", 32'(m_retry), 32'd3);
        chk("exh_queue", exp_q.size(), 0);
        acmd_dflt = 8'd1;

        // timeout: card never answers CMD0
        silent_cmd = 3'd1;
        push(3'd1, 32'h0);
        pulse_start();
        n = 0;
        while (!m_send && n < 500) begin n++; @(negedge clk); end
        t = 0;
        while (!m_err && t < 1000) begin @(negedge clk); t++; end
        chk("tmo_window", 32'(t >= 100 && t <= 104), 32'd1);
        chk("tmo_code", 32'(m_code), 32'hF0);
        chk("tmo_ecmd", 32'(m_ecmd), 32'd1);
        chk("tmo_cs", 32'(m_cs), 32'd1);
        chk("tmo_queue", exp_q.size(), 0);
        silent_cmd = 3'd0;

        // reset while ACMD41 waits for its response
        sel_b = 1'b0;
        ackonly_cmd = 3'd7;
        push(3'd1, 32'h0); push(3'd5, 32'h0); push(3'd7, 32'h4000_0000);
        pulse_start();
        n = 0;
        while (m_sel != 3'd7 && n < 2000) begin n++; @(negedge clk); end
        while (m_sel == 3'd7 && n < 2000) begin n++; @(negedge clk); end
        chk("rsp_wait_reached", 32'(n < 2000), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_values();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ackonly_cmd = 3'd0;
        repeat (40) @(negedge clk);
        chk("post_rst_busy", 32'(m_busy), 32'd0);
        chk("post_rst_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
